// File: rtl/moore_seq_ctrl.sv
// Sequencer that clears a Moore recognizer, shifts a stored pattern into it LSB first
// and counts MATCH_CODE cycles on its output. Optional first-hit capture: MOORE_SEQ_FIRST_HIT_EN.
module moore_seq_ctrl #(
    parameter int         PAT_W      = 16,
    parameter int         CNT_W      = 5,
    parameter logic [1:0] MATCH_CODE = 2'b11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    output logic             fsm_reset,
    output logic             fsm_a,
    input  logic [1:0]       fsm_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
`ifdef MOORE_SEQ_FIRST_HIT_EN
    ,
    output logic [CNT_W-1:0] first_hit_idx,
    output logic             first_hit_vld
`endif
);

    typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   r_shift;
    logic [CNT_W-1:0]   r_rem;
    logic               r_fsm_a;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic               r_samp_en;
    logic [CNT_W-1:0]   w_len_clamp;
    logic               w_hit;
`ifdef MOORE_SEQ_FIRST_HIT_EN
    logic [CNT_W-1:0]   r_samp_idx;
    logic [CNT_W-1:0]   r_fh_idx;
    logic               r_fh_vld;
`endif

    assign w_len_clamp = (len > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : len;
    assign w_hit       = r_samp_en && (fsm_b == MATCH_CODE);

    assign fsm_reset = reset | (r_state == CLR);
    assign fsm_a     = r_fsm_a;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hit_cnt   = r_hit_cnt;
`ifdef MOORE_SEQ_FIRST_HIT_EN
    assign first_hit_idx = r_fh_idx;
    assign first_hit_vld = r_fh_vld;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_rem     <= '0;
            r_fsm_a   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hit_cnt <= '0;
            r_samp_en <= 1'b0;
`ifdef MOORE_SEQ_FIRST_HIT_EN
            r_samp_idx <= '0;
            r_fh_idx   <= '0;
            r_fh_vld   <= 1'b0;
`endif
        end else begin
            // The recognizer output lags a_in by one clock, so sampling trails the driven bit.
            r_samp_en <= (r_state == RUN);
            r_done    <= 1'b0;
            if (w_hit && (r_hit_cnt != '1))
                r_hit_cnt <= r_hit_cnt + 1'b1;
`ifdef MOORE_SEQ_FIRST_HIT_EN
            if (r_samp_en) begin
                r_samp_idx <= r_samp_idx + 1'b1;
                if (w_hit && !r_fh_vld) begin
                    r_fh_idx <= r_samp_idx;
                    r_fh_vld <= 1'b1;
                end
            end
`endif
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift   <= pattern;
                        r_rem     <= w_len_clamp;
                        r_hit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= CLR;
`ifdef MOORE_SEQ_FIRST_HIT_EN
                        r_samp_idx <= '0;
                        r_fh_idx   <= '0;
                        r_fh_vld   <= 1'b0;
`endif
                    end
                end
                CLR: begin
                    if (r_rem == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_fsm_a <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_rem   <= r_rem - 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (r_rem == '0) begin
                        r_fsm_a <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_fsm_a <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_rem   <= r_rem - 1'b1;
                    end
                end
                DRAIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_fsm_a <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
